// File: rtl/trig_counter_bank_pkg.sv
// Shared definitions for the trigger-driven counter bank: readback word geometry
// and the per-channel operation decoded each cycle.
package trig_counter_bank_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_INC,
        OP_DEC
    } ch_op_e;

    // Number of 16-bit readback words needed to cover a counter of cnt_w bits.
    function automatic int num_words(input int cnt_w);
        return (cnt_w + WORD_W - 1) / WORD_W;
    endfunction

endpackage

// File: rtl/trig_counter_bank_updown_counter_ch.sv
// One counter channel: priority decode of clear/load/step, wrap or saturate at the
// boundaries, and a one-cycle terminal-count pulse for boundary steps.
module updown_counter_ch
    import trig_counter_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             trig_rst,
    input  logic             trig_load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             trig_up,
    input  logic             trig_down,
    input  logic             free_run,
    input  logic             saturate,
    output logic [CNT_W-1:0] count,
    output logic             tc_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ch_op_e op;
    logic   inc;
    logic   dec;

    assign inc = trig_up | free_run;
    assign dec = trig_down;

    always_comb begin
        // NOTE: op gets a default before any branch so no path can infer a latch.
        op = OP_HOLD;
        if (trig_rst)
            op = OP_CLR;
        else if (trig_load)
            op = OP_LOAD;
        else if (inc && !dec)
            op = OP_INC;
        else if (dec && !inc)
            op = OP_DEC;
    end

    // NOTE: all registered state uses non-blocking assignment so every flop sees pre-edge values.
    always_ff @(posedge clk1) begin
        if (reset) begin
            count    <= '0;
            tc_pulse <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            unique case (op)
                OP_CLR:  count <= '0;
                OP_LOAD: count <= load_val;
                OP_INC: begin
                    if (count == CNT_MAX) begin
                        tc_pulse <= 1'b1;
                        if (!saturate)
                            count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                OP_DEC: begin
                    if (count == '0) begin
                        tc_pulse <= 1'b1;
                        if (!saturate)
                            count <= CNT_MAX;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/trig_counter_bank.sv
// Bank of NUM_CH trigger-driven up/down counters with a coherent all-channel
// snapshot and a registered 16-bit readback mux over the snapshot registers.
module trig_counter_bank
    import trig_counter_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_AW  = 2,
    parameter int WD_AW  = 1
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trig_rst,
    input  logic [NUM_CH-1:0] trig_load,
    input  logic [CNT_W-1:0]  load_val,
    input  logic [NUM_CH-1:0] trig_up,
    input  logic [NUM_CH-1:0] trig_down,
    input  logic [NUM_CH-1:0] free_run,
    input  logic [NUM_CH-1:0] saturate,
    input  logic              snap,
    input  logic [CH_AW-1:0]  rd_ch,
    input  logic [WD_AW-1:0]  rd_word,
    output logic [15:0]       rd_data,
    output logic [NUM_CH-1:0] tc_pulse,
    output logic              snap_done
);

    localparam int NUM_WORDS = num_words(CNT_W);
    localparam int PAD_W     = WORD_W * NUM_WORDS;

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [PAD_W-1:0]  sel_pad;
    logic [WORD_W-1:0] rd_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        updown_counter_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk1      (clk1),
            .reset     (reset),
            .trig_rst  (trig_rst[g]),
            .trig_load (trig_load[g]),
            .load_val  (load_val),
            .trig_up   (trig_up[g]),
            .trig_down (trig_down[g]),
            .free_run  (free_run[g]),
            .saturate  (saturate[g]),
            .count     (cnt[g]),
            .tc_pulse  (tc_pulse[g])
        );
    end

    // Unmatched channel or word selects fall through to the zero defaults.
    always_comb begin
        sel_pad = '0;
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (rd_ch == CH_AW'(c))
                sel_pad[CNT_W-1:0] = snap_q[c];
        for (int w = 0; w < NUM_WORDS; w++)
            if (rd_word == WD_AW'(w))
                rd_next = sel_pad[w*WORD_W +: WORD_W];
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            // NOTE: snapshot registers are explicitly cleared because readback after reset must be 0.
            for (int c = 0; c < NUM_CH; c++)
                snap_q[c] <= '0;
            snap_done <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (snap)
                for (int c = 0; c < NUM_CH; c++)
                    snap_q[c] <= cnt[c];
            snap_done <= snap;
            rd_data   <= rd_next;
        end
    end

endmodule
